// File: rtl/gppm_sequencer.sv
// Two-phase (FETCH/EXEC) microsequencer driving a GPPM register-file/ALU datapath
// from an external combinational-read instruction memory, with a run watchdog.
module gppm_sequencer #(
    parameter int PC_W      = 8,
    parameter int MAX_INSTR = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [51:0]     imem_data,
    output logic [3:0]      raddr1,
    output logic [3:0]      raddr2,
    output logic [3:0]      waddr,
    output logic            wen,
    output logic            wdsrc,
    output logic [3:0]      func,
    output logic [31:0]     constant,
    output logic [31:0]     aluconst,
    output logic            alusrc,
    input  logic            isZero
);

    localparam int CNT_W = (MAX_INSTR > 32'sd0) ? $clog2(MAX_INSTR + 32'sd1) : 1;
    localparam bit WD_EN = (MAX_INSTR != 32'sd0);
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_INSTR);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDI  = 4'd1;
    localparam logic [3:0] OP_ALUR = 4'd2;
    localparam logic [3:0] OP_ALUI = 4'd3;
    localparam logic [3:0] OP_BZ   = 4'd4;
    localparam logic [3:0] OP_BNZ  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_HALT = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [PC_W-1:0]   pc_r, pc_s;
    logic [51:0]       ir_r, ir_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic              done_r, done_s;
    logic              err_r, err_s;
    logic              halt_s, illegal_s, wd_hit_s;

    logic [3:0]        op_s, func_f_s, rd_s, rs1_s, rs2_s;
    logic [31:0]       imm_s;
    logic [PC_W-1:0]   pc_inc_s, imm_pc_s;

    assign op_s     = ir_r[51:48];
    assign func_f_s = ir_r[47:44];
    assign rd_s     = ir_r[43:40];
    assign rs1_s    = ir_r[39:36];
    assign rs2_s    = ir_r[35:32];
    assign imm_s    = ir_r[31:0];
    assign pc_inc_s = pc_r + PC_W'(1'b1);
    assign imm_pc_s = imm_s[PC_W-1:0];

    // Next-state, program-counter, watchdog count and termination status.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        ir_s      = ir_r;
        count_s   = count_r;
        done_s    = 1'b0;
        err_s     = err_r;
        halt_s    = 1'b0;
        illegal_s = 1'b0;
        wd_hit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                    pc_s    = '0;
                    count_s = '0;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                ir_s    = imem_data;
                state_s = ST_EXEC;
            end
            ST_EXEC: begin
                count_s  = count_r + CNT_W'(1'b1);
                wd_hit_s = WD_EN && (count_s == WD_LIMIT);
                case (op_s)
                    OP_NOP, OP_LDI, OP_ALUR, OP_ALUI: pc_s = pc_inc_s;
                    OP_BZ:   pc_s = isZero ? imm_pc_s : pc_inc_s;
                    OP_BNZ:  pc_s = isZero ? pc_inc_s : imm_pc_s;
                    OP_JMP:  pc_s = imm_pc_s;
                    OP_HALT: halt_s = 1'b1;
                    default: begin
                        halt_s    = 1'b1;
                        illegal_s = 1'b1;
                    end
                endcase
                // A halting op wins over the watchdog: its err reflects only legality.
                if (halt_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    err_s   = illegal_s;
                end else if (wd_hit_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= '0;
            ir_r    <= '0;
            count_r <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            ir_r    <= ir_s;
            count_r <= count_s;
            done_r  <= done_s;
            err_r   <= err_s;
        end
    end

    // GPPM control decode; everything is quiet outside the EXEC cycle.
    always_comb begin
        raddr1   = 4'd0;
        raddr2   = 4'd0;
        waddr    = 4'd0;
        wen      = 1'b0;
        wdsrc    = 1'b0;
        func     = 4'd0;
        constant = 32'd0;
        aluconst = 32'd0;
        alusrc   = 1'b0;
        if (state_r == ST_EXEC) begin
            case (op_s)
                OP_LDI: begin
                    wen      = 1'b1;
                    waddr    = rd_s;
                    constant = imm_s;
                end
                OP_ALUR, OP_ALUI: begin
                    raddr1   = rs1_s;
                    raddr2   = rs2_s;
                    func     = func_f_s;
                    wdsrc    = 1'b1;
                    wen      = 1'b1;
                    waddr    = rd_s;
                    alusrc   = (op_s == OP_ALUI);
                    aluconst = (op_s == OP_ALUI) ? imm_s : 32'd0;
                end
                OP_BZ, OP_BNZ: begin
                    raddr1 = rs1_s;
                    raddr2 = rs2_s;
                    func   = func_f_s;
                end
                default: wen = 1'b0;
            endcase
        end else begin
            wen = 1'b0;
        end
    end

    assign busy      = (state_r != ST_IDLE);
    assign done      = done_r;
    assign err       = err_r;
    assign pc        = pc_r;
    assign imem_addr = pc_r;

endmodule

// File: tb/tb_gppm_sequencer.sv
// Bench for gppm_sequencer: an instruction-level interpreter builds the expected
// per-cycle output trace of each run; directed literal checks pin that model.
module tb_gppm_sequencer;

    localparam int PC_W = 8;
    localparam int MAXI = 4;

    logic        clk, rst_n, start, isZero;
    logic        busy, done, err, wen, wdsrc, alusrc;
    logic [7:0]  pc, imem_addr;
    logic [51:0] imem_data;
    logic [3:0]  raddr1, raddr2, waddr, func;
    logic [31:0] constant, aluconst;

    logic [51:0] imem [256];
    logic        iz;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        busy, done, err;
        logic [7:0]  pc;
        logic [3:0]  raddr1, raddr2, waddr;
        logic        wen, wdsrc;
        logic [3:0]  func;
        logic [31:0] constant;
        logic        alusrc;
        logic [31:0] aluconst;
    } rec_t;

    rec_t q[$];
    rec_t cur;
    rec_t act;

    gppm_sequencer #(.PC_W(PC_W), .MAX_INSTR(MAXI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .pc(pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .raddr1(raddr1), .raddr2(raddr2), .waddr(waddr), .wen(wen), .wdsrc(wdsrc),
        .func(func), .constant(constant), .aluconst(aluconst), .alusrc(alusrc),
        .isZero(isZero)
    );

    assign imem_data = imem[imem_addr];
    assign isZero    = iz;
    assign act = '{busy: busy, done: done, err: err, pc: pc, raddr1: raddr1, raddr2: raddr2,
                   waddr: waddr, wen: wen, wdsrc: wdsrc, func: func, constant: constant,
                   alusrc: alusrc, aluconst: aluconst};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic rec_t idle_rec(input logic [7:0] p, input logic e);
        rec_t r;
        r = '0;
        r.pc  = p;
        r.err = e;
        return r;
    endfunction

    // Control fields an instruction word asks of the datapath while it executes.
    function automatic rec_t decode(input logic [51:0] w);
        rec_t r;
        int   op;
        r  = '0;
        op = int'(w[51:48]);
        if (op == 1) begin
            r.wen = 1'b1; r.waddr = w[43:40]; r.constant = w[31:0];
        end else if (op == 2 || op == 3) begin
            r.raddr1 = w[39:36]; r.raddr2 = w[35:32]; r.func = w[47:44];
            r.wdsrc = 1'b1; r.wen = 1'b1; r.waddr = w[43:40];
            if (op == 3) begin
                r.alusrc = 1'b1; r.aluconst = w[31:0];
            end
        end else if (op == 4 || op == 5) begin
            r.raddr1 = w[39:36]; r.raddr2 = w[35:32]; r.func = w[47:44];
        end
        return r;
    endfunction

    // Interpret the program from address 0, pushing two cycles per instruction plus the done cycle.
    task automatic gen_trace();
        logic [7:0]  p, np;
        logic [51:0] w;
        int          op, n;
        bit          fin;
        logic        e;
        rec_t        r;
        p = 8'd0; n = 0; fin = 1'b0;
        while (!fin && n < 1000) begin
            w = imem[p];
            op = int'(w[51:48]);
            r = idle_rec(p, 1'b0); r.busy = 1'b1;
            q.push_back(r);
            r = decode(w); r.busy = 1'b1; r.pc = p;
            q.push_back(r);
            n++;
            e  = 1'b0;
            np = p + 8'd1;
            if (op == 4 && iz) np = w[7:0];
            if (op == 5 && !iz) np = w[7:0];
            if (op == 6) np = w[7:0];
            if (op >= 7) begin
                fin = 1'b1;
                e   = (op > 7);
                np  = p;
            end else if (n == MAXI) begin
                fin = 1'b1;
                e   = 1'b1;
            end
            if (fin) begin
                r = idle_rec(np, e); r.done = 1'b1;
                q.push_back(r);
            end
            p = np;
        end
    endtask

    // Reference model: advance the expected trace each clock, accept start while idle.
    initial begin
        cur = idle_rec(8'd0, 1'b0);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                cur = idle_rec(8'd0, 1'b0);
            end else begin
                if (!cur.busy && start) gen_trace();
                if (q.size() > 0) cur = q.pop_front();
                else cur = idle_rec(cur.pc, cur.err);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                n_checks++;
                if (act === cur) n_pass++;
                else $display("FAIL trace t=%0t got %h expected %h", $time, act, cur);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, a, e);
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 52'd0;
    endtask

    task automatic put(input int a, input logic [3:0] op, input logic [3:0] f, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2, input logic [31:0] imm);
        imem[a] = {op, f, rd, rs1, rs2, imm};
    endtask

    // Start pulse; returns inside cycle 1 (FETCH of address 0), so skip(n) lands in cycle n.
    task automatic do_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done !== 1'b1 && k < limit);
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation bound expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; iz = 1'b0;
        clear_mem();
        skip(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // LDI then HALT
        put(0, 4'd1, 4'd0, 4'd3, 4'd0, 4'd0, 32'h1234);
        put(1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        do_start();
        skip(2);
        chk("ldi_wen", {31'd0, wen}, 32'd1);
        chk("ldi_waddr", {28'd0, waddr}, 32'd3);
        chk("ldi_wdsrc", {31'd0, wdsrc}, 32'd0);
        chk("ldi_const", constant, 32'h1234);
        skip(3);
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        chk("halt_err", {31'd0, err}, 32'd0);
        chk("halt_pc", {24'd0, pc}, 32'd1);
        skip(1);
        chk("done_pulse_len", {31'd0, done}, 32'd0);

        // ALUI
        put(0, 4'd3, 4'd5, 4'd2, 4'd1, 4'd0, 32'd7);
        do_start();
        skip(2);
        chk("alui_raddr1", {28'd0, raddr1}, 32'd1);
        chk("alui_alusrc", {31'd0, alusrc}, 32'd1);
        chk("alui_aluconst", aluconst, 32'd7);
        chk("alui_func", {28'd0, func}, 32'd5);
        chk("alui_wdsrc", {31'd0, wdsrc}, 32'd1);
        chk("alui_wen", {31'd0, wen}, 32'd1);
        chk("alui_waddr", {28'd0, waddr}, 32'd2);
        skip(1);
        chk("alui_pc", {24'd0, pc}, 32'd1);
        wait_done(20);

        // BZ taken / not taken
        clear_mem();
        put(0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 32'd4);
        put(4, 4'd4, 4'd3, 4'd0, 4'd1, 4'd2, 32'h20);
        put(32'h20, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        put(5, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        iz = 1'b1;
        do_start();
        skip(4);
        chk("bz_wen", {31'd0, wen}, 32'd0);
        skip(1);
        chk("bz_taken_addr", {24'd0, imem_addr}, 32'h20);
        wait_done(20);
        iz = 1'b0;
        do_start();
        skip(4);
        chk("bz_nt_wen", {31'd0, wen}, 32'd0);
        skip(1);
        chk("bz_nt_addr", {24'd0, imem_addr}, 32'd5);
        wait_done(20);

        // Illegal opcode, then restart clears err
        clear_mem();
        put(0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 32'd9);
        put(9, 4'hC, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        do_start();
        skip(5);
        chk("ill_done", {31'd0, done}, 32'd1);
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_pc", {24'd0, pc}, 32'd9);
        do_start();
        skip(1);
        chk("restart_err", {31'd0, err}, 32'd0);
        chk("restart_pc", {24'd0, pc}, 32'd0);
        wait_done(20);
        chk("ill2_err", {31'd0, err}, 32'd1);

        // Watchdog on JMP 0 loop
        clear_mem();
        put(0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        do_start();
        skip(8);
        chk("wd_no_done_yet", {31'd0, done}, 32'd0);
        skip(1);
        chk("wd_done", {31'd0, done}, 32'd1);
        chk("wd_err", {31'd0, err}, 32'd1);
        chk("wd_pc", {24'd0, pc}, 32'd0);

        // pc wrap from 0xFF
        put(0, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 32'hFF);
        put(255, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        do_start();
        skip(3);
        chk("wrap_pc_ff", {24'd0, pc}, 32'hFF);
        skip(2);
        chk("wrap_pc_0", {24'd0, pc}, 32'd0);
        skip(4);
        chk("wrap_wd_done", {31'd0, done}, 32'd1);
        chk("wrap_wd_err", {31'd0, err}, 32'd1);

        // HALT as the MAX_INSTR-th instruction is a clean halt
        clear_mem();
        put(3, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        do_start();
        skip(9);
        chk("halt4_done", {31'd0, done}, 32'd1);
        chk("halt4_err", {31'd0, err}, 32'd0);
        chk("halt4_pc", {24'd0, pc}, 32'd3);

        // Reset during a writing EXEC
        clear_mem();
        put(0, 4'd1, 4'd0, 4'd3, 4'd0, 4'd0, 32'hAA);
        put(1, 4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        do_start();
        skip(2);
        chk("pre_rst_wen", {31'd0, wen}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_wen", {31'd0, wen}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        skip(2);
        @(posedge clk); #2 rst_n = 1'b1;
        skip(3);
        chk("post_rst_done", {31'd0, done}, 32'd0);
        put(1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        do_start();
        wait_done(20);
        chk("post_rst_err", {31'd0, err}, 32'd0);
        chk("post_rst_pc", {24'd0, pc}, 32'd1);
        skip(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
